// File: rtl/choque_pkg.sv
// Shared types and constants for the car-vs-obstacles collision detector.
package choque_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EVAL = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int XW_DEF   = 10;
  localparam int YW_DEF   = 9;

  // One extra bit so that box right/bottom edges past the screen never wrap.
  function automatic int cmp_width(input int xw, input int yw);
    return ((xw > yw) ? xw : yw) + 1;
  endfunction

endpackage

// File: rtl/choque_box_cmp.sv
// Combinational overlap test of one obstacle box against the car box.
module choque_box_cmp
  import choque_pkg::*;
#(
  parameter int XW    = XW_DEF,
  parameter int YW    = YW_DEF,
  parameter int CAR_Y = 400,
  parameter int CAR_W = 40,
  parameter int CAR_H = 60,
  parameter int OBS_W = 64,
  parameter int OBS_H = 48
) (
  input  logic [XW-1:0] ox_i,
  input  logic [YW-1:0] oy_i,
  input  logic [XW-1:0] carx_i,
  input  logic          valid_i,
  output logic          hit_o
);

  localparam int CW = cmp_width(XW, YW);

  logic [CW-1:0] ox, oy, cx;

  assign ox = CW'(ox_i);
  assign oy = CW'(oy_i);
  assign cx = CW'(carx_i);

  // Strict compares: boxes that only share an edge do not overlap.
  assign hit_o = valid_i
              && (ox < cx + CW'(CAR_W))
              && (cx < ox + CW'(OBS_W))
              && (oy < CW'(CAR_Y + CAR_H))
              && (CW'(CAR_Y) < oy + CW'(OBS_H));

endmodule

// File: rtl/choque_multi.sv
// Frame-synchronous collision detector: scans N_OBS obstacles per frame with one
// shared comparator, debounces crashes, manages grace window, lives and game over.
module choque_multi
  import choque_pkg::*;
#(
  parameter int N_OBS        = 4,
  parameter int XW           = XW_DEF,
  parameter int YW           = YW_DEF,
  parameter int CAR_Y        = 400,
  parameter int CAR_W        = 40,
  parameter int CAR_H        = 60,
  parameter int OBS_W        = 64,
  parameter int OBS_H        = 48,
  parameter int HIT_FRAMES   = 2,
  parameter int GRACE_FRAMES = 30,
  parameter int LIVES        = 3
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic                iFrameTick,
  input  logic [N_OBS*XW-1:0] iPosX,
  input  logic [N_OBS*YW-1:0] iPosY,
  input  logic [N_OBS-1:0]    iValid,
  input  logic [XW-1:0]       iPosCarX,
  input  logic                iClear,
  output logic                oHit,
  output logic [3:0]          oHitIdx,
  output logic [2:0]          oLives,
  output logic                oStop,
  output logic                oGrace,
  output logic                oOverrun
);

  localparam int IW = (N_OBS > 1) ? $clog2(N_OBS) : 1;
  localparam int HW = $clog2(HIT_FRAMES + 1);
  localparam int GW = (GRACE_FRAMES > 1) ? $clog2(GRACE_FRAMES + 1) : 1;

  state_e state_q, state_d;

  logic [N_OBS-1:0][XW-1:0] posx_q;
  logic [N_OBS-1:0][YW-1:0] posy_q;
  logic [N_OBS-1:0]         valid_q;
  logic [XW-1:0]            carx_q;
  logic                     snap_en;

  logic [IW-1:0] idx_q, idx_d;
  logic          anyhit_q, anyhit_d;
  logic [IW-1:0] hitidx_q, hitidx_d;
  logic [HW-1:0] hitcnt_q, hitcnt_d;
  logic [GW-1:0] grace_q, grace_d;
  logic [2:0]    lives_q, lives_d;
  logic          stop_q, stop_d;
  logic          overrun_q, overrun_d;
  logic          hit_q, hit_d;
  logic [IW-1:0] hitidx_o_q, hitidx_o_d;
  logic          cmp_hit;

  choque_box_cmp #(
    .XW(XW), .YW(YW), .CAR_Y(CAR_Y), .CAR_W(CAR_W), .CAR_H(CAR_H),
    .OBS_W(OBS_W), .OBS_H(OBS_H)
  ) u_cmp (
    .ox_i    (posx_q[idx_q]),
    .oy_i    (posy_q[idx_q]),
    .carx_i  (carx_q),
    .valid_i (valid_q[idx_q]),
    .hit_o   (cmp_hit)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    anyhit_d   = anyhit_q;
    hitidx_d   = hitidx_q;
    hitcnt_d   = hitcnt_q;
    grace_d    = grace_q;
    lives_d    = lives_q;
    stop_d     = stop_q;
    overrun_d  = overrun_q;
    hit_d      = 1'b0;
    hitidx_o_d = hitidx_o_q;
    snap_en    = 1'b0;

    if (iClear) begin
      state_d    = ST_IDLE;
      idx_d      = '0;
      anyhit_d   = 1'b0;
      hitidx_d   = '0;
      hitcnt_d   = '0;
      grace_d    = '0;
      lives_d    = 3'(LIVES);
      stop_d     = 1'b0;
      overrun_d  = 1'b0;
      hitidx_o_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (iFrameTick) begin
            // During grace a frame tick only burns one grace frame.
            if (grace_q != '0) begin
              grace_d = grace_q - GW'(1);
            end else begin
              snap_en  = 1'b1;
              idx_d    = '0;
              anyhit_d = 1'b0;
              hitidx_d = '0;
              state_d  = ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (iFrameTick) overrun_d = 1'b1;
          if (cmp_hit && !anyhit_q) hitidx_d = idx_q;
          anyhit_d = anyhit_q | cmp_hit;
          if (idx_q == IW'(N_OBS - 1)) state_d = ST_EVAL;
          else                         idx_d   = idx_q + IW'(1);
        end
        ST_EVAL: begin
          if (iFrameTick) overrun_d = 1'b1;
          state_d = ST_IDLE;
          if (!anyhit_q) begin
            hitcnt_d = '0;
          end else if (hitcnt_q == HW'(HIT_FRAMES - 1)) begin
            hit_d      = 1'b1;
            hitidx_o_d = hitidx_q;
            lives_d    = lives_q - 3'd1;
            hitcnt_d   = '0;
            grace_d    = GW'(GRACE_FRAMES);
            if (lives_q == 3'd1) begin
              stop_d  = 1'b1;
              state_d = ST_OVER;
            end
          end else begin
            hitcnt_d = hitcnt_q + HW'(1);
          end
        end
        ST_OVER: stop_d = 1'b1;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      anyhit_q   <= 1'b0;
      hitidx_q   <= '0;
      hitcnt_q   <= '0;
      grace_q    <= '0;
      lives_q    <= 3'(LIVES);
      stop_q     <= 1'b0;
      overrun_q  <= 1'b0;
      hit_q      <= 1'b0;
      hitidx_o_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      anyhit_q   <= anyhit_d;
      hitidx_q   <= hitidx_d;
      hitcnt_q   <= hitcnt_d;
      grace_q    <= grace_d;
      lives_q    <= lives_d;
      stop_q     <= stop_d;
      overrun_q  <= overrun_d;
      hit_q      <= hit_d;
      hitidx_o_q <= hitidx_o_d;
    end
  end

  // Inputs are only looked at here, so movement mid-scan cannot skew a frame.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      posx_q  <= '0;
      posy_q  <= '0;
      valid_q <= '0;
      carx_q  <= '0;
    end else if (snap_en) begin
      posx_q  <= iPosX;
      posy_q  <= iPosY;
      valid_q <= iValid;
      carx_q  <= iPosCarX;
    end
  end

  assign oHit     = hit_q;
  assign oHitIdx  = 4'(hitidx_o_q);
  assign oLives   = lives_q;
  assign oStop    = stop_q;
  assign oGrace   = (grace_q != '0);
  assign oOverrun = overrun_q;

endmodule
